mem_port_arbiter: RTL

//  Shares the single-port 1024x32 word-addressed unified memory between three requesters:

---
 rtl/mem_port_arbiter_pkg.sv | 33 +++
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter_pick.sv | 39 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Package: mem_arb_pkg
//   Port indices, port vector/index types, arbiter FSM state enum and a
//   one-hot to index helper.
package mem_arb_pkg;

   localparam int unsigned NUM_PORTS  = 3;
   localparam int unsigned PORT_FETCH = 0;
   localparam int unsigned PORT_DATA  = 1;
   localparam int unsigned PORT_DBG   = 2;
   localparam int unsigned PIDX_W     = 2;

   typedef logic [NUM_PORTS-1:0] port_vec_t;
   typedef logic [PIDX_W-1:0]    port_idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Index of the set bit of a one-hot port vector (0 when empty).
   function automatic port_idx_t onehot_to_idx(input port_vec_t oh);
      port_idx_t idx;
      idx = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (oh[i]) idx = port_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the memory port arbiter.
// Interface: mem_port_arbiter_if #(AW, DW)
//   req/we/addr/wdata   per-port request bundle (port i at slice i)
//   gnt/rvalid/rdata    per-port grant and read response
//   mem_*               single-port memory access bus
// Modports: slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 32
);
   port_vec_t                 req;
   port_vec_t                 we;
   logic [NUM_PORTS*AW-1:0]   addr;
   logic [NUM_PORTS*DW-1:0]   wdata;
   port_vec_t                 gnt;
   port_vec_t                 rvalid;
   logic [DW-1:0]             rdata;
   logic                      mem_en;
   logic                      mem_we;
   logic [AW-1:0]             mem_addr;
   logic [DW-1:0]             mem_wdata;
   logic [DW-1:0]             mem_rdata;

   modport slave (
      input  req, we, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, we, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational request picker for the memory port arbiter.
// Module: mem_arb_pick
//   req_i       per-port request vector
//   last_win_i  index of the previous winner (rotating mode only)
//   win_c_o     one-hot winner
//   valid_c_o   any request present
// Config macro MEM_ARB_ROUND_ROBIN_EN selects rotating priority starting
// after last_win_i; otherwise fixed priority port 2 > port 1 > port 0.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  port_vec_t req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  port_idx_t last_win_i,
`endif
   output port_vec_t win_c_o,
   output logic      valid_c_o
);

   always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      port_idx_t idx;
      win_c_o = '0;
      idx     = '0;
      // Scan the ports in order following the last winner, wrapping at 3.
      for (int k = 1; k <= int'(NUM_PORTS); k++) begin
         idx = port_idx_t'((int'(last_win_i) + k) % int'(NUM_PORTS));
         if ((win_c_o == '0) && req_i[idx]) win_c_o[idx] = 1'b1;
      end
`else
      win_c_o = '0;
      if (req_i[PORT_DBG])        win_c_o[PORT_DBG]   = 1'b1;
      else if (req_i[PORT_DATA])  win_c_o[PORT_DATA]  = 1'b1;
      else if (req_i[PORT_FETCH]) win_c_o[PORT_FETCH] = 1'b1;
`endif
      valid_c_o = |req_i;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-port arbiter in front of a single-port word-addressed memory.
// One access in flight; read data returned READ_LAT cycles after issue.
// Module: mem_port_arbiter #(AW, DW, READ_LAT)
//   clk     system clock
//   reset   synchronous active-high reset
//   bus_io  mem_port_arbiter_if.slave: requests, grants, read response,
//           memory access bus
// Config macro MEM_ARB_ROUND_ROBIN_EN enables rotating priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW       = 10,
   parameter int unsigned DW       = 32,
   parameter int unsigned READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus_io
);

   localparam int unsigned CNT_W = $clog2(READ_LAT + 1);

   if (READ_LAT < 1) begin : g_bad_read_lat
      $error("mem_port_arbiter: READ_LAT must be at least 1");
   end

   state_e            state_q;
   port_vec_t         gnt_q;
   port_vec_t         rvalid_q;
   port_vec_t         owner_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [AW-1:0]     mem_addr_q;
   logic [DW-1:0]     mem_wdata_q;
   logic [DW-1:0]     rdata_q;
   logic [CNT_W-1:0]  cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   port_idx_t         last_win_q;
`endif

   port_vec_t         win_c;
   logic              pick_valid_c;
   port_idx_t         win_idx_c;

   mem_arb_pick u_pick (
      .req_i      (bus_io.req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .last_win_i (last_win_q),
`endif
      .win_c_o    (win_c),
      .valid_c_o  (pick_valid_c)
   );

   assign win_idx_c = onehot_to_idx(win_c);

   // Arbiter FSM; gnt/mem strobes/rvalid are one-cycle pulses cleared by default.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         rvalid_q    <= '0;
         owner_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         cnt_q       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_win_q  <= port_idx_t'(PORT_DBG);
`endif
      end else begin
         gnt_q    <= '0;
         rvalid_q <= '0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_valid_c) begin
                  // Latch the winner's request straight into the memory bus registers.
                  owner_q     <= win_c;
                  gnt_q       <= win_c;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= bus_io.we[win_idx_c];
                  mem_addr_q  <= bus_io.addr[32'(win_idx_c) * AW +: AW];
                  mem_wdata_q <= bus_io.wdata[32'(win_idx_c) * DW +: DW];
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_win_q  <= win_idx_c;
`endif
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               // mem_we_q is high here exactly for writes, which finish now.
               if (mem_we_q) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q   <= CNT_W'(READ_LAT);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               // Count of 1 marks the cycle ACCESS+READ_LAT where mem_rdata is valid.
               if (cnt_q == CNT_W'(1)) begin
                  rdata_q  <= bus_io.mem_rdata;
                  rvalid_q <= owner_q;
                  state_q  <= RESP;
               end
               cnt_q <= cnt_q - CNT_W'(1);
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus_io.gnt       = gnt_q;
   assign bus_io.rvalid    = rvalid_q;
   assign bus_io.rdata     = rdata_q;
   assign bus_io.mem_en    = mem_en_q;
   assign bus_io.mem_we    = mem_we_q;
   assign bus_io.mem_addr  = mem_addr_q;
   assign bus_io.mem_wdata = mem_wdata_q;

endmodule
